and2_gate: RTL and testbench
============================

# and2_gate

Two-input AND primitive with a registered shadow output and input-combination coverage tracking. Output Y is the purely combinational AND of A and B, settling in the same simulation time step as an input change. A one-cycle registered copy and a 4-bit coverage mask let lab benches and upstream logic confirm that every truth-table row has been exercised. The block sits at the leaf level of the lab logic-gate library.

## Interface
- WIDTH, 1: bit width of A, B, Y, Y_r; the AND is bitwise. Legal range 1..64.
- clk  input  1  single clock; all registers are rising-edge triggered.
- rst  input  1  reset, asynchronous and active-high; clears every register.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- in_valid  input  1  qualifies A/B for the registered path and coverage.
- cov_clr  input  1  synchronous clear of the coverage mask.
- Y  output  WIDTH  A & B, combinational.
- Y_r  output  WIDTH  registered A & B.
- out_valid  output  1  Y_r holds a valid result.
- cov  output  4  bit k set once the row {A[0],B[0]} == k has been seen with in_valid=1.
- cov_full  output  1  cov == 4'b1111.

## Operation
- Y = A & B, bitwise, at all times, including during reset; no X propagation beyond IEEE AND semantics (0 & X = 0).
- On a rising clk edge with in_valid=1: Y_r <= A & B, out_valid <= 1.
- On a rising clk edge with in_valid=0: Y_r holds its value, out_valid <= 0.
- Coverage indexes on bit 0 only: row index = {A[0], B[0]}, where 00->bit0, 01->bit1, 10->bit2, 11->bit3.
- On a rising clk edge with in_valid=1, cov[row] <= 1. Bits are sticky.
- cov_clr=1 clears cov to 0 on the next edge. If in_valid=1 on the same edge, the clear wins and the current row is not recorded.
- cov_full is combinational from cov.
- Reset values: Y_r=0, out_valid=0, cov=0, cov_full=0. Y is unaffected by reset.

## Timing
- Y: zero-cycle latency; pure combinational path A/B -> Y.
- Y_r and out_valid: 1-cycle latency from the in_valid sample edge.
- cov: updates 1 cycle after the sampling edge; cov_full follows cov in the same cycle.
- rst assertion clears registers immediately, without waiting for clk.
- Deassertion of rst is synchronised externally. The first edge after deassertion samples normally.
- Reset mid-operation discards any in-flight Y_r and drops out_valid immediately.
- No backpressure: every in_valid beat produces exactly one out_valid beat.

## Structure
- No shared package is required.
- Coverage index constants (ROW_00..ROW_11) may be placed in a lab-wide gates_pkg if other gate blocks adopt the same coverage scheme.
- One natural sub-module, tt_cov: it takes a 2-bit row index, a valid and a clear, and returns the 4-bit sticky mask. It is reused by the sibling or/xor gate blocks.
- The combinational AND and the output register live in the top module.

## Test plan
- Exhaustive truth table at WIDTH=1: apply A,B = 00, 01, 10, 11 with 10 ns spacing. Y must be 0, 0, 0, 1 within the same time step.
- Registered path: in_valid=1 with A=1, B=1 on edge n. Y_r=1 and out_valid=1 after edge n; with in_valid=0 at edge n+1, out_valid=0 and Y_r stays 1.
- Coverage: drive the four rows in the order 00, 01, 10, 11 with in_valid=1. cov progresses 0001, 0011, 0111, 1111; cov_full=1 after the fourth edge.
- Clear priority: with cov=1111, assert cov_clr=1 and in_valid=1 with A=1, B=1 together. cov=0000 after the edge.
- Async reset: with out_valid=1, Y_r=1 and cov=1111, pulse rst between clock edges. All registers read 0 before the next edge, while Y still equals A & B.
- WIDTH=8: A=8'hF0, B=8'h3C must give Y=8'h30; the coverage row comes from bit 0 (0,0 -> cov bit0).

Source files
------------

// File: rtl/and2_gate_pkg.sv
// Shared types and helpers for the and2_gate leaf cell and its truth-table coverage tracker.
// Row encoding is {A[0], B[0]}, so sibling gate blocks can reuse the same coverage scheme.
package and2_gate_pkg;

    localparam int COV_W = 4;

    localparam logic [COV_W-1:0] COV_ALL_ROWS = 4'b1111;

    typedef enum logic [1:0] {
        ROW_00 = 2'b00,
        ROW_01 = 2'b01,
        ROW_10 = 2'b10,
        ROW_11 = 2'b11
    } tt_row_e;

    function automatic tt_row_e row_of(input logic a0, input logic b0);
        return tt_row_e'({a0, b0});
    endfunction

    function automatic logic [COV_W-1:0] row_onehot(input tt_row_e r);
        logic [COV_W-1:0] m;
        m = '0;
        m[r] = 1'b1;
        return m;
    endfunction

    function automatic logic cov_is_full(input logic [COV_W-1:0] m);
        return (m == COV_ALL_ROWS);
    endfunction

endpackage

// File: rtl/and2_gate_if.sv
// Operand/result bundle for the and2_gate cell.
// The master side drives operands and qualifiers; the slave side (the gate) returns results and coverage.
interface and2_gate_if
    import and2_gate_pkg::*;
#(
    parameter int WIDTH = 1
);

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             in_valid;
    logic             cov_clr;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] Y_r;
    logic             out_valid;
    logic [COV_W-1:0] cov;
    logic             cov_full;

    modport master (
        output A,
        output B,
        output in_valid,
        output cov_clr,
        input  Y,
        input  Y_r,
        input  out_valid,
        input  cov,
        input  cov_full
    );

    modport slave (
        input  A,
        input  B,
        input  in_valid,
        input  cov_clr,
        output Y,
        output Y_r,
        output out_valid,
        output cov,
        output cov_full
    );

endinterface

// File: rtl/and2_gate_tt_cov.sv
// Sticky truth-table row coverage mask, shared with the sibling two-input gate cells.
// A clear on the same edge as a valid sample wins, so the sampled row is dropped.
module and2_gate_tt_cov
    import and2_gate_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  tt_row_e          row,
    input  logic             valid,
    input  logic             clr,
    output logic [COV_W-1:0] cov
);

    logic [COV_W-1:0] cov_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cov_q <= '0;
        end else if (clr) begin
            cov_q <= '0;
        end else if (valid) begin
            cov_q <= cov_q | row_onehot(row);
        end
    end

    assign cov = cov_q;

endmodule

// File: rtl/and2_gate.sv
// Bitwise two-input AND leaf cell with a one-cycle registered shadow copy and row coverage.
// Y is purely combinational and stays live through reset; only the shadow path is cleared.
module and2_gate
    import and2_gate_pkg::*;
#(
    parameter int WIDTH = 1
)
(
    input  logic     clk,
    input  logic     rst,
    and2_gate_if.slave bus
);

    logic [WIDTH-1:0] y_comb;
    logic [WIDTH-1:0] y_r_q;
    logic             out_valid_q;
    logic [COV_W-1:0] cov_mask;
    tt_row_e          row;

    assign y_comb = bus.A & bus.B;
    assign row    = row_of(bus.A[0], bus.B[0]);

    // Y_r only updates on a qualified beat; out_valid tracks in_valid beat for beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_r_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                y_r_q <= y_comb;
            end
        end
    end

    and2_gate_tt_cov u_tt_cov (
        .clk   (clk),
        .rst   (rst),
        .row   (row),
        .valid (bus.in_valid),
        .clr   (bus.cov_clr),
        .cov   (cov_mask)
    );

    assign bus.Y         = y_comb;
    assign bus.Y_r       = y_r_q;
    assign bus.out_valid = out_valid_q;
    assign bus.cov       = cov_mask;
    assign bus.cov_full  = cov_is_full(cov_mask);

endmodule

// File: tb/tb_and2_gate.sv
// Directed self-checking bench for and2_gate at WIDTH=1 and WIDTH=8.
// Inputs change on the falling edge; registered outputs are sampled 1 ns after the rising edge.
module tb_and2_gate;

    logic clk;
    logic rst;

    int checkCount;
    int passCount;

    and2_gate_if #(.WIDTH(1)) bus1 ();
    and2_gate_if #(.WIDTH(8)) bus8 ();

    and2_gate #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    and2_gate #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic b, input logic valid, input logic clr);
        @(negedge clk);
        bus1.A        = a;
        bus1.B        = b;
        bus1.in_valid = valid;
        bus1.cov_clr  = clr;
    endtask

    task automatic waitSample();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rowVec [4];
    logic [3:0] covExp [4];

    initial begin
        checkCount = 0;
        passCount  = 0;
        rowVec = '{2'b00, 2'b01, 2'b10, 2'b11};
        covExp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

        rst           = 1'b1;
        bus1.A        = 1'b0;
        bus1.B        = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.cov_clr  = 1'b0;
        bus8.A        = 8'h00;
        bus8.B        = 8'h00;
        bus8.in_valid = 1'b0;
        bus8.cov_clr  = 1'b0;

        // Reset state, and Y must stay combinational while reset is held.
        @(posedge clk);
        #1;
        checkOutput("reset_y_r", bus1.Y_r, 1'b0);
        checkOutput("reset_out_valid", bus1.out_valid, 1'b0);
        checkOutput("reset_cov", bus1.cov, 4'b0000);
        checkOutput("reset_cov_full", bus1.cov_full, 1'b0);
        bus1.A = 1'b1;
        bus1.B = 1'b1;
        #1;
        checkOutput("reset_y_live", bus1.Y, 1'b1);

        @(negedge clk);
        rst = 1'b0;

        // Exhaustive truth table with in_valid low; coverage must not move.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(rowVec[i][1], rowVec[i][0], 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("tt_y_%0d", i), bus1.Y, (i == 3) ? 1'b1 : 1'b0);
        end
        waitSample();
        checkOutput("tt_cov_untouched", bus1.cov, 4'b0000);
        checkOutput("tt_out_valid_low", bus1.out_valid, 1'b0);

        // Registered path: one valid beat of 1&1, then an idle beat with new operands.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        waitSample();
        checkOutput("reg_y_r", bus1.Y_r, 1'b1);
        checkOutput("reg_out_valid", bus1.out_valid, 1'b1);
        checkOutput("reg_cov_row11", bus1.cov, 4'b1000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        waitSample();
        checkOutput("hold_out_valid", bus1.out_valid, 1'b0);
        checkOutput("hold_y_r", bus1.Y_r, 1'b1);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        waitSample();
        checkOutput("clr_cov", bus1.cov, 4'b0000);

        // Coverage sweep in row order.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(rowVec[i][1], rowVec[i][0], 1'b1, 1'b0);
            waitSample();
            checkOutput($sformatf("cov_step_%0d", i), bus1.cov, covExp[i]);
            checkOutput($sformatf("cov_full_step_%0d", i), bus1.cov_full, (i == 3) ? 1'b1 : 1'b0);
        end

        // Clear and valid on the same edge: clear wins, result path still updates.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        waitSample();
        checkOutput("prio_cov", bus1.cov, 4'b0000);
        checkOutput("prio_cov_full", bus1.cov_full, 1'b0);
        checkOutput("prio_y_r", bus1.Y_r, 1'b1);
        checkOutput("prio_out_valid", bus1.out_valid, 1'b1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(rowVec[i][1], rowVec[i][0], 1'b1, 1'b0);
            waitSample();
        end
        checkOutput("pre_rst_cov", bus1.cov, 4'b1111);
        checkOutput("pre_rst_out_valid", bus1.out_valid, 1'b1);

        // Async reset pulse between edges, then the next edge samples normally.
        #1;
        rst = 1'b1;
        #1;
        checkOutput("arst_y_r", bus1.Y_r, 1'b0);
        checkOutput("arst_out_valid", bus1.out_valid, 1'b0);
        checkOutput("arst_cov", bus1.cov, 4'b0000);
        checkOutput("arst_cov_full", bus1.cov_full, 1'b0);
        checkOutput("arst_y_live", bus1.Y, 1'b1);
        #1;
        rst = 1'b0;
        waitSample();
        checkOutput("post_rst_out_valid", bus1.out_valid, 1'b1);
        checkOutput("post_rst_cov", bus1.cov, 4'b1000);

        // Wide instance: bitwise AND, coverage from bit 0 only.
        @(negedge clk);
        bus8.A        = 8'hF0;
        bus8.B        = 8'h3C;
        bus8.in_valid = 1'b1;
        #1;
        checkOutput("w8_y", bus8.Y, 8'h30);
        waitSample();
        checkOutput("w8_y_r", bus8.Y_r, 8'h30);
        checkOutput("w8_cov_row00", bus8.cov, 4'b0001);
        @(negedge clk);
        bus8.A = 8'hFF;
        bus8.B = 8'h0F;
        #1;
        checkOutput("w8_y_b", bus8.Y, 8'h0F);
        waitSample();
        checkOutput("w8_y_r_b", bus8.Y_r, 8'h0F);
        checkOutput("w8_cov_row11", bus8.cov, 4'b1001);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        waitSample();
        checkOutput("w8_out_valid_low", bus8.out_valid, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
